// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the stack unit: word width, stack status
// encodings and the {psh,pop} command encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_PART  = 2'b01,
        S_FULL  = 2'b10
    } stack_state_e;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_REPL = 2'b11
    } stack_cmd_e;

endpackage

// File: rtl/stack_unit_ram.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port. The array is intentionally not reset.
module stack_unit_ram
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO stack: push/pop/replace/bypass with saturating stack pointer,
// registered pop data, full/empty status and sticky overflow/underflow flags.
module stack_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned SP_W = $clog2(DEPTH) + 1,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_psh,
    input  logic              i_pop,
    input  logic              i_clr_err,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_pop_vld,
    output logic [SP_W-1:0]   o_sp,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_ovf,
    output logic              o_unf
);

    stack_cmd_e        w_cmd;
    stack_state_e      r_state;
    logic [SP_W-1:0]   r_sp;
    logic [SP_W-1:0]   w_sp_nxt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_pop_vld;
    logic              r_ovf;
    logic              r_unf;
    logic              w_empty;
    logic              w_full;
    logic [AW-1:0]     w_top_addr;
    logic [AW-1:0]     w_waddr;
    logic              w_we;
    logic              w_pop_ok;
    logic [DATA_W-1:0] w_pop_data;
    logic [DATA_W-1:0] w_rdata;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_cmd      = stack_cmd_e'({i_psh, i_pop});
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == SP_W'(DEPTH));
    assign w_top_addr = AW'(r_sp - SP_W'(1));

    stack_unit_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_data_in),
        .i_raddr (w_top_addr),
        .o_rdata (w_rdata)
    );

    // Command decode; top-of-stack read and write share the sp-1 address on replace.
    always_comb begin
        w_sp_nxt   = r_sp;
        w_we       = 1'b0;
        w_waddr    = w_top_addr;
        w_pop_ok   = 1'b0;
        w_pop_data = w_rdata;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        if (i_en) begin
            case (w_cmd)
                CMD_PUSH: begin
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_waddr  = AW'(r_sp);
                        w_sp_nxt = r_sp + SP_W'(1);
                    end
                end
                CMD_POP: begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                    end else begin
                        w_pop_ok = 1'b1;
                        w_sp_nxt = r_sp - SP_W'(1);
                    end
                end
                CMD_REPL: begin
                    w_pop_ok = 1'b1;
                    if (w_empty) begin
                        w_pop_data = i_data_in;
                    end else begin
                        w_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sp       <= '0;
            r_data_out <= '0;
            r_pop_vld  <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_pop_vld <= w_pop_ok;
            if (i_en) begin
                r_sp  <= w_sp_nxt;
                r_ovf <= (r_ovf & ~i_clr_err) | w_ovf_set;
                r_unf <= (r_unf & ~i_clr_err) | w_unf_set;
                if (w_pop_ok) begin
                    r_data_out <= w_pop_data;
                end
            end
        end
    end

    // Status FSM; replace and bypass never move it, errors never move it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_EMPTY;
        end else if (i_en) begin
            case (r_state)
                S_EMPTY: begin
                    if (w_cmd == CMD_PUSH) begin
                        r_state <= S_PART;
                    end
                end
                S_PART: begin
                    if (w_cmd == CMD_PUSH && r_sp == SP_W'(DEPTH - 1)) begin
                        r_state <= S_FULL;
                    end else if (w_cmd == CMD_POP && r_sp == SP_W'(1)) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_cmd == CMD_POP) begin
                        r_state <= S_PART;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    a_state_tracks_sp: assert property (@(posedge i_clk) disable iff (!i_rst)
        (((r_state == S_EMPTY) == w_empty) && ((r_state == S_FULL) == w_full)));

    assign o_data_out = r_data_out;
    assign o_pop_vld  = r_pop_vld;
    assign o_sp       = r_sp;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_ovf      = r_ovf;
    assign o_unf      = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus randomized
// traffic compared against a queue-based LIFO model.
module tb_stack_unit;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SP_W  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            psh;
    logic            pop;
    logic            clr_err;
    logic [DW-1:0]   data_in;
    logic [DW-1:0]   data_out;
    logic            pop_vld;
    logic [SP_W-1:0] sp;
    logic            empty;
    logic            full;
    logic            ovf;
    logic            unf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    logic          m_ovf;
    logic          m_unf;

    stack_unit #(.DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_psh      (psh),
        .i_pop      (pop),
        .i_clr_err  (clr_err),
        .i_data_in  (data_in),
        .o_data_out (data_out),
        .o_pop_vld  (pop_vld),
        .o_sp       (sp),
        .o_empty    (empty),
        .o_full     (full),
        .o_ovf      (ovf),
        .o_unf      (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Apply one request at the negedge, let the DUT clock it, advance the model, settle.
    task automatic cyc(input logic e, input logic ps, input logic pp, input logic clr,
                       input logic [DW-1:0] d);
        @(negedge clk);
        en = e; psh = ps; pop = pp; clr_err = clr; data_in = d;
        @(posedge clk);
        m_vld = 1'b0;
        if (e) begin
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ps && !pp) begin
                if (q.size() == DEPTH) m_ovf = 1'b1;
                else q.push_back(d);
            end else if (pp && !ps) begin
                if (q.size() == 0) m_unf = 1'b1;
                else begin
                    m_dout = q.pop_back();
                    m_vld  = 1'b1;
                end
            end else if (pp && ps) begin
                m_vld = 1'b1;
                if (q.size() == 0) m_dout = d;
                else begin
                    m_dout = q[q.size()-1];
                    q[q.size()-1] = d;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        cyc(1, 1, 0, 0, 16'h1111);
        cyc(1, 1, 0, 0, 16'h2222);
        @(negedge clk);
        psh = 1'b1; data_in = 16'h3333;
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (sp !== '0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0 ||
            data_out !== '0 || pop_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: sp=%0d empty=%b full=%b ovf=%b unf=%b dout=%h vld=%b, want 0 1 0 0 0 0000 0",
                     sp, empty, full, ovf, unf, data_out, pop_vld);
        end
        @(negedge clk);
        psh = 1'b0;
        rst = 1'b1;
        cyc(1, 0, 0, 0, 16'h0);
        checks++;
        if (sp !== '0 || empty !== 1'b1 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_release: sp=%0d empty=%b dout=%h, want 0 1 0000", sp, empty, data_out);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 1, 0, 0, 16'(i));
        end
        checks++;
        if (full !== 1'b1 || sp !== SP_W'(16) || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b sp=%0d empty=%b, want 1 16 0", full, sp, empty);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 1, 0, 16'h0);
            checks++;
            if (data_out !== 16'(16 - i) || pop_vld !== 1'b1) begin
                errors++;
                $display("FAIL drain_pop%0d: dout=%h vld=%b, want %h 1", i, data_out, pop_vld, 16'(16 - i));
            end
        end
        cyc(1, 0, 0, 0, 16'h0);
        checks++;
        if (empty !== 1'b1 || pop_vld !== 1'b0 || sp !== '0 || data_out !== 16'h0001) begin
            errors++;
            $display("FAIL drain_end: empty=%b vld=%b sp=%0d dout=%h, want 1 0 0 0001", empty, pop_vld, sp, data_out);
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = data_out;
        cyc(1, 0, 1, 0, 16'h0);
        checks++;
        if (unf !== 1'b1 || sp !== '0 || pop_vld !== 1'b0 || data_out !== prev) begin
            errors++;
            $display("FAIL underflow: unf=%b sp=%0d vld=%b dout=%h, want 1 0 0 %h", unf, sp, pop_vld, data_out, prev);
        end
        cyc(1, 0, 1, 1, 16'h0);
        checks++;
        if (unf !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_error: unf=%b, want 1", unf);
        end
        cyc(1, 0, 0, 1, 16'h0);
        checks++;
        if (unf !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: unf=%b ovf=%b, want 0 0", unf, ovf);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] last;
        last = '0;
        for (int i = 0; i < 16; i++) begin
            last = 16'($urandom);
            cyc(1, 1, 0, 0, last);
        end
        cyc(1, 1, 0, 0, 16'hBEEF);
        checks++;
        if (ovf !== 1'b1 || sp !== SP_W'(16) || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ovf=%b sp=%0d full=%b, want 1 16 1", ovf, sp, full);
        end
        cyc(1, 0, 1, 0, 16'h0);
        checks++;
        if (data_out !== last || sp !== SP_W'(15) || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pop: dout=%h sp=%0d ovf=%b, want %h 15 1", data_out, sp, ovf, last);
        end
        cyc(1, 0, 0, 1, 16'h0);
        while (q.size() > 0) cyc(1, 0, 1, 0, 16'h0);
        checks++;
        if (empty !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: empty=%b ovf=%b, want 1 0", empty, ovf);
        end
    endtask

    task automatic test_replace();
        cyc(1, 1, 0, 0, 16'h0011);
        cyc(1, 1, 0, 0, 16'h0022);
        cyc(1, 1, 0, 0, 16'h00AA);
        cyc(1, 1, 1, 0, 16'h1234);
        checks++;
        if (data_out !== 16'h00AA || sp !== SP_W'(3) || pop_vld !== 1'b1) begin
            errors++;
            $display("FAIL replace: dout=%h sp=%0d vld=%b, want 00aa 3 1", data_out, sp, pop_vld);
        end
        cyc(1, 0, 1, 0, 16'h0);
        checks++;
        if (data_out !== 16'h1234 || sp !== SP_W'(2)) begin
            errors++;
            $display("FAIL replace_pop: dout=%h sp=%0d, want 1234 2", data_out, sp);
        end
        // Replace while full must be legal and not flag overflow
        while (q.size() < DEPTH) cyc(1, 1, 0, 0, 16'($urandom));
        cyc(1, 1, 1, 0, 16'hCAFE);
        checks++;
        if (ovf !== 1'b0 || sp !== SP_W'(16) || pop_vld !== 1'b1 || data_out !== m_dout) begin
            errors++;
            $display("FAIL replace_full: ovf=%b sp=%0d vld=%b dout=%h, want 0 16 1 %h", ovf, sp, pop_vld, data_out, m_dout);
        end
        cyc(1, 0, 1, 0, 16'h0);
        checks++;
        if (data_out !== 16'hCAFE) begin
            errors++;
            $display("FAIL replace_full_pop: dout=%h, want cafe", data_out);
        end
        while (q.size() > 0) cyc(1, 0, 1, 0, 16'h0);
    endtask

    task automatic test_bypass_en();
        cyc(1, 1, 1, 0, 16'h5A5A);
        checks++;
        if (data_out !== 16'h5A5A || pop_vld !== 1'b1 || sp !== '0 || unf !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL bypass: dout=%h vld=%b sp=%0d unf=%b empty=%b, want 5a5a 1 0 0 1",
                     data_out, pop_vld, sp, unf, empty);
        end
        cyc(0, 1, 0, 0, 16'h7777);
        checks++;
        if (sp !== '0 || pop_vld !== 1'b0) begin
            errors++;
            $display("FAIL en_low_push: sp=%0d vld=%b, want 0 0", sp, pop_vld);
        end
        cyc(0, 0, 1, 0, 16'h0);
        checks++;
        if (unf !== 1'b0 || sp !== '0) begin
            errors++;
            $display("FAIL en_low_pop: unf=%b sp=%0d, want 0 0", unf, sp);
        end
        cyc(1, 1, 0, 0, 16'h4321);
        cyc(0, 0, 1, 0, 16'h0);
        checks++;
        if (sp !== SP_W'(1) || pop_vld !== 1'b0 || data_out !== 16'h5A5A) begin
            errors++;
            $display("FAIL en_low_hold: sp=%0d vld=%b dout=%h, want 1 0 5a5a", sp, pop_vld, data_out);
        end
    endtask

    task automatic test_random();
        int r;
        logic e, ps, pp, c;
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 9);
            // Drift toward full in the first half and toward empty in the second
            if (n < 300) begin ps = (r < 6) || (r == 9); pp = (r >= 6); end
            else         begin ps = (r < 3) || (r == 9); pp = (r >= 3); end
            cyc(e, ps, pp, c, 16'($urandom));
            checks++;
            if (sp !== SP_W'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                pop_vld !== m_vld || data_out !== m_dout || ovf !== m_ovf || unf !== m_unf) begin
                errors++;
                $display("FAIL random[%0d]: sp=%0d e=%b f=%b vld=%b dout=%h ovf=%b unf=%b, want %0d %b %b %b %h %b %b",
                         n, sp, empty, full, pop_vld, data_out, ovf, unf, q.size(), (q.size() == 0),
                         (q.size() == DEPTH), m_vld, m_dout, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; psh = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_overflow();
        test_replace();
        test_bypass_en();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
